call_responder: RTL and testbench
=================================

Name: call_responder

Overview:
- Callee/responder side of the team's function-call request/response interface.
- Accepts one call request at a time: function code, tag and three operands on a valid/ready handshake.
- Evaluates the function, either in a single cycle or iteratively over multiple cycles, then returns the result with the same tag on a second valid/ready handshake.
- Sits behind any caller block that issues hierarchical-style calls into a shared evaluator instance.

Parameters:
- DATA_W, 8, operand width in bits (DATA_W >= 2).
- TAG_W, 4, request/response tag width.
- RES_W, 2*DATA_W+1, result width. Derived; callers must not override it.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req_valid  input  1  request present.
- req_ready  output  1  responder accepts a request this cycle.
- req_fn  input  2  function code: 0=SUM3, 1=SEL, 2=MAC, 3=reserved.
- req_tag  input  TAG_W  caller tag, returned unchanged on the response.
- req_a  input  DATA_W  operand a.
- req_b  input  DATA_W  operand b.
- req_c  input  DATA_W  operand c.
- rsp_valid  output  1  response present.
- rsp_ready  input  1  caller accepts the response.
- rsp_tag  output  TAG_W  tag of the request being answered.
- rsp_data  output  RES_W  function result, zero-extended.
- rsp_err  output  1  request carried an unsupported function code.
- call_cnt  output  16  completed responses, saturating at 0xFFFF.

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE.
  - rsp_valid=0, rsp_tag=0, rsp_data=0, rsp_err=0, call_cnt=0.
  - Multiply accumulator and bit counter cleared.
  - Reset mid-operation discards the in-flight call; no response is ever produced for it.
- States:
  - IDLE: no call held.
  - BUSY: iterative MAC in progress.
  - HOLD: response held on the output.
- Handshake:
  - Request accepted on a clock edge where req_valid & req_ready.
  - Response retired on a clock edge where rsp_valid & rsp_ready.
  - req_ready = (state==IDLE) | (state==HOLD & rsp_ready). This is a combinational rsp_ready->req_ready path, allowing back-to-back calls.
  - rsp_valid = (state==HOLD).
  - rsp_tag, rsp_data and rsp_err hold stable while rsp_valid=1 and rsp_ready=0.
- Functions:
  - SUM3: a+b+c, computed at DATA_W+2 bits then zero-extended to RES_W. Goes IDLE->HOLD, so rsp_valid rises on the edge after acceptance (latency 1).
  - SEL: result = (a!=0) ? b : c, zero-extended. Latency 1.
  - MAC: a*b+c by shift-add, one bit of b per cycle, LSB first.
    - Accept loads acc=c, mcand=a, mplier=b, cnt=0, then goes to BUSY.
    - Each BUSY edge: if mplier[0], acc += mcand; then mcand<<=1, mplier>>=1, cnt++.
    - On the edge where cnt reaches DATA_W-1, go to HOLD.
    - rsp_valid is asserted DATA_W+1 edges after the accept edge.
    - No early exit when mplier is zero; latency is fixed.
    - Maximum value (2^DATA_W-1)^2 + 2^DATA_W-1 fits RES_W, so there is no overflow.
  - Code 3: rsp_err=1 and rsp_data=0. Latency 1.
- HOLD exit:
  - On rsp_ready, call_cnt++ (saturating).
  - If a new request is accepted on the same edge, its result or BUSY load replaces the held one with no bubble.
  - Otherwise go to IDLE.
- In BUSY, req_ready=0; req_* values are ignored.

Decomposition:
- Shared package call_pkg:
  - function-code constants FN_SUM3, FN_SEL, FN_MAC, FN_RSVD.
  - state encoding constants ST_IDLE, ST_BUSY, ST_HOLD.
  - DATA_W/TAG_W defaults.
- One sub-module: call_mac_iter, the shift-add datapath with load/step/done. The FSM, handshake and counter stay in call_responder.

Test Plan:
- SUM3, a=b=c=8'hFF, rsp_ready=1 -> rsp_valid one cycle after accept, rsp_data=17'h002FD, rsp_err=0, tag echoed, call_cnt=1.
- SEL a=0,b=8'h11,c=8'h22 then a=1 with the same b/c, issued back-to-back with rsp_ready held 1 -> responses 8'h22 then 8'h11 on consecutive cycles, req_ready never drops.
- MAC a=200,b=100,c=50 -> rsp_valid exactly 9 edges after the accept edge, rsp_data=17'h04E52. Also a=b=8'hFF, c=8'hFF -> 17'h0FF00.
- Backpressure: SUM3 response held with rsp_ready=0 for 5 cycles while req_valid=1 -> req_ready=0 throughout, outputs stable. Raise rsp_ready -> retire and accept on the same edge.
- fn=3 with tag 4'hA -> rsp_err=1, rsp_data=0, rsp_tag=4'hA, call_cnt increments.
- rst_n pulsed low during MAC BUSY (cnt=3) -> rsp_valid=0 immediately, state IDLE, call_cnt=0, no stale response after release. Separately, force call_cnt=0xFFFF and retire one more response -> stays 0xFFFF.

Source files
------------

// File: rtl/call_pkg.sv
// Shared definitions for the function-call responder: function codes, FSM states, width defaults.
package call_pkg;
  localparam int CALL_DATA_W = 8;
  localparam int CALL_TAG_W  = 4;

  localparam logic [1:0] FN_SUM3 = 2'd0;
  localparam logic [1:0] FN_SEL  = 2'd1;
  localparam logic [1:0] FN_MAC  = 2'd2;
  localparam logic [1:0] FN_RSVD = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_HOLD = 2'd2
  } state_t;
endpackage

// File: rtl/call_mac_iter.sv
// Shift-add a*b+c, one multiplier bit per step (LSB first); fixed DATA_W steps, no early exit.
// result is the post-step accumulator so the owner can capture it on the done edge.
module call_mac_iter #(
  parameter int  DATA_W = 8,
  localparam int RES_W  = 2*DATA_W+1,
  localparam int CNT_W  = $clog2(DATA_W)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              step,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [DATA_W-1:0] c,
  output logic [RES_W-1:0]  result,
  output logic              done
);
  logic [RES_W-1:0]  acc;
  logic [RES_W-1:0]  mcand;
  logic [DATA_W-1:0] mplier;
  logic [CNT_W-1:0]  cnt;

  assign result = mplier[0] ? (acc + mcand) : acc;
  assign done   = step & (cnt == CNT_W'(DATA_W-1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
    end else if (load) begin
      acc    <= RES_W'(c);
      mcand  <= RES_W'(a);
      mplier <= b;
      cnt    <= '0;
    end else if (step) begin
      acc    <= result;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + CNT_W'(1);
    end
  end
endmodule

// File: rtl/call_responder.sv
// Callee side of the call interface: one request at a time, SUM3/SEL/reserved answer in 1 edge, MAC in DATA_W+1.
// Response held until rsp_ready; a retiring response lets a new request in on the same edge.
module call_responder
  import call_pkg::*;
#(
  parameter int  DATA_W = CALL_DATA_W,
  parameter int  TAG_W  = CALL_TAG_W,
  localparam int RES_W  = 2*DATA_W+1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_fn,
  input  logic [TAG_W-1:0]  req_tag,
  input  logic [DATA_W-1:0] req_a,
  input  logic [DATA_W-1:0] req_b,
  input  logic [DATA_W-1:0] req_c,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [TAG_W-1:0]  rsp_tag,
  output logic [RES_W-1:0]  rsp_data,
  output logic              rsp_err,
  output logic [15:0]       call_cnt
);
  state_t             state;
  logic               req_fire;
  logic               mac_load;
  logic               mac_step;
  logic               mac_done;
  logic [RES_W-1:0]   mac_result;
  logic [RES_W-1:0]   quick_data;
  logic [DATA_W+1:0]  sum3;

  // Combinational rsp_ready -> req_ready keeps back-to-back calls bubble-free.
  assign req_ready = (state == ST_IDLE) | ((state == ST_HOLD) & rsp_ready);
  assign rsp_valid = (state == ST_HOLD);
  assign req_fire  = req_valid & req_ready;
  assign mac_load  = req_fire & (req_fn == FN_MAC);
  assign mac_step  = (state == ST_BUSY);
  assign sum3      = {2'b00, req_a} + {2'b00, req_b} + {2'b00, req_c};

  always_comb begin
    quick_data = '0;
    case (req_fn)
      FN_SUM3: quick_data = RES_W'(sum3);
      FN_SEL:  quick_data = RES_W'((req_a != '0) ? req_b : req_c);
      default: quick_data = '0;
    endcase
  end

  call_mac_iter #(.DATA_W(DATA_W)) u_mac (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (mac_load),
    .step   (mac_step),
    .a      (req_a),
    .b      (req_b),
    .c      (req_c),
    .result (mac_result),
    .done   (mac_done)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      rsp_tag  <= '0;
      rsp_data <= '0;
      rsp_err  <= 1'b0;
      call_cnt <= '0;
    end else begin
      if (rsp_valid && rsp_ready && (call_cnt != 16'hFFFF))
        call_cnt <= call_cnt + 16'd1;
      case (state)
        ST_BUSY: begin
          if (mac_done) begin
            state    <= ST_HOLD;
            rsp_data <= mac_result;
            rsp_err  <= 1'b0;
          end
        end
        default: begin
          // IDLE and HOLD both admit a new call; the held response is replaced without a bubble.
          if (req_fire) begin
            rsp_tag <= req_tag;
            if (req_fn == FN_MAC) begin
              state <= ST_BUSY;
            end else begin
              state    <= ST_HOLD;
              rsp_data <= quick_data;
              rsp_err  <= (req_fn == FN_RSVD);
            end
          end else if (rsp_ready) begin
            state <= ST_IDLE;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_call_responder.sv
// Bench for call_responder: table of calls checked through a response scoreboard,
// plus hand sequences for latency, back-to-back, backpressure, reset abort and counter saturation.
module tb_call_responder;
  import call_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_fn;
  logic [3:0]  req_tag;
  logic [7:0]  req_a, req_b, req_c;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [3:0]  rsp_tag;
  logic [16:0] rsp_data;
  logic        rsp_err;
  logic [15:0] call_cnt;

  always #5 clk = ~clk;

  call_responder #(.DATA_W(8), .TAG_W(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_fn    (req_fn),
    .req_tag   (req_tag),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_c     (req_c),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_tag   (rsp_tag),
    .rsp_data  (rsp_data),
    .rsp_err   (rsp_err),
    .call_cnt  (call_cnt)
  );

  typedef struct {
    logic [1:0]  fn;
    logic [3:0]  tag;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [7:0]  c;
    logic [16:0] data;
    logic        err;
  } vec_t;

  typedef struct {
    logic [3:0]  tag;
    logic [16:0] data;
    logic        err;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        pend;
  vec_t        vt[9];
  int          total = 0;
  int          bad = 0;
  logic [15:0] exp_cnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, want);
    end
  endtask

  function automatic exp_t model(input logic [1:0] fn, input logic [3:0] tag,
                                 input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    exp_t e;
    e.tag  = tag;
    e.err  = 1'b0;
    e.data = '0;
    case (fn)
      2'd0:    e.data = 17'(a) + 17'(b) + 17'(c);
      2'd1:    e.data = (a != 8'd0) ? 17'(b) : 17'(c);
      2'd2:    e.data = 17'(a) * 17'(b) + 17'(c);
      default: e.err  = 1'b1;
    endcase
    return e;
  endfunction

  // One clock: sample handshakes mid-low-phase, score responses, log accepted requests.
  task automatic tick(output bit accepted);
    exp_t e;
    #1;
    accepted = req_valid && req_ready;
    if (rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_rsp: got tag %h data %h want no response", rsp_tag, rsp_data);
      end else begin
        e = exp_q.pop_front();
        chk("rsp_tag", 32'(rsp_tag), 32'(e.tag));
        chk("rsp_data", 32'(rsp_data), 32'(e.data));
        chk("rsp_err", 32'(rsp_err), 32'(e.err));
        if (exp_cnt != 16'hFFFF) exp_cnt++;
      end
    end
    if (accepted) exp_q.push_back(pend);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic [1:0] fn, input logic [3:0] tag,
                       input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    req_fn  = fn;
    req_tag = tag;
    req_a   = a;
    req_b   = b;
    req_c   = c;
    pend    = model(fn, tag, a, b, c);
  endtask

  task automatic send();
    bit ok;
    ok = 1'b0;
    req_valid = 1'b1;
    for (int i = 0; i < 40 && !ok; i++) tick(ok);
    req_valid = 1'b0;
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL accept_timeout: got no accept want accept within 40 cycles");
    end
  endtask

  task automatic drain();
    bit d;
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) tick(d);
    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain_timeout: got %0d pending want 0", exp_q.size());
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit   acc;
    int   edges;
    bit   seen;

    vt[0] = '{FN_SUM3, 4'h1, 8'h01, 8'h02, 8'h03, 17'h00006, 1'b0};
    vt[1] = '{FN_SUM3, 4'h2, 8'hFF, 8'hFF, 8'hFF, 17'h002FD, 1'b0};
    vt[2] = '{FN_SEL,  4'h3, 8'h00, 8'h11, 8'h22, 17'h00022, 1'b0};
    vt[3] = '{FN_SEL,  4'h4, 8'h80, 8'h11, 8'h22, 17'h00011, 1'b0};
    vt[4] = '{FN_MAC,  4'h5, 8'hFF, 8'hFF, 8'hFF, 17'h0FF00, 1'b0};
    vt[5] = '{FN_MAC,  4'h6, 8'h00, 8'h37, 8'h05, 17'h00005, 1'b0};
    vt[6] = '{FN_MAC,  4'h7, 8'd200, 8'd100, 8'd50, 17'h04E52, 1'b0};
    vt[7] = '{FN_RSVD, 4'hA, 8'h12, 8'h34, 8'h56, 17'h00000, 1'b1};
    vt[8] = '{FN_MAC,  4'h9, 8'h01, 8'hFF, 8'h00, 17'h000FF, 1'b0};

    rst_n = 1'b0; req_valid = 1'b0; rsp_ready = 1'b1;
    req_fn = '0; req_tag = '0; req_a = '0; req_b = '0; req_c = '0;
    exp_cnt = '0;
    pend = model(2'd0, 4'h0, 8'h0, 8'h0, 8'h0);

    @(negedge clk);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_tag", 32'(rsp_tag), 32'd0);
    chk("rst_rsp_data", 32'(rsp_data), 32'd0);
    chk("rst_rsp_err", 32'(rsp_err), 32'd0);
    chk("rst_call_cnt", 32'(call_cnt), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    rst_n = 1'b1;
    @(negedge clk);

    // SUM3 latency 1
    drive(FN_SUM3, 4'h3, 8'hFF, 8'hFF, 8'hFF);
    req_valid = 1'b1;
    tick(acc);
    req_valid = 1'b0;
    chk("sum3_accept", 32'(acc), 32'd1);
    chk("sum3_latency", 32'(rsp_valid), 32'd1);
    tick(acc);
    chk("sum3_call_cnt", 32'(call_cnt), 32'd1);

    // SEL back-to-back
    drive(FN_SEL, 4'h1, 8'h00, 8'h11, 8'h22);
    req_valid = 1'b1;
    tick(acc);
    chk("sel1_valid", 32'(rsp_valid), 32'd1);
    chk("sel1_data", 32'(rsp_data), 32'h22);
    chk("sel1_req_ready", 32'(req_ready), 32'd1);
    drive(FN_SEL, 4'h2, 8'h01, 8'h11, 8'h22);
    tick(acc);
    chk("sel2_accept", 32'(acc), 32'd1);
    chk("sel2_valid", 32'(rsp_valid), 32'd1);
    chk("sel2_data", 32'(rsp_data), 32'h11);
    chk("sel2_req_ready", 32'(req_ready), 32'd1);
    req_valid = 1'b0;
    drain();

    // MAC fixed latency
    drive(FN_MAC, 4'h5, 8'd200, 8'd100, 8'd50);
    req_valid = 1'b1;
    tick(acc);
    req_valid = 1'b0;
    chk("mac_accept", 32'(acc), 32'd1);
    edges = 1;
    while (!rsp_valid && edges < 40) begin
      tick(acc);
      edges++;
    end
    chk("mac_latency", 32'(edges), 32'd9);
    chk("mac_data", 32'(rsp_data), 32'h04E52);
    drain();

    // Table of calls
    for (int i = 0; i < 9; i++) begin
      req_fn = vt[i].fn; req_tag = vt[i].tag;
      req_a = vt[i].a; req_b = vt[i].b; req_c = vt[i].c;
      pend.tag = vt[i].tag; pend.data = vt[i].data; pend.err = vt[i].err;
      send();
      drain();
      chk("tbl_call_cnt", 32'(call_cnt), 32'(exp_cnt));
    end

    // Backpressure while a second request waits
    drive(FN_SUM3, 4'h6, 8'd1, 8'd2, 8'd3);
    req_valid = 1'b1;
    tick(acc);
    rsp_ready = 1'b0;
    drive(FN_SUM3, 4'h7, 8'd10, 8'd20, 8'd30);
    for (int i = 0; i < 5; i++) begin
      tick(acc);
      chk("bp_no_accept", 32'(acc), 32'd0);
      chk("bp_valid", 32'(rsp_valid), 32'd1);
      chk("bp_data", 32'(rsp_data), 32'd6);
      chk("bp_tag", 32'(rsp_tag), 32'h6);
    end
    rsp_ready = 1'b1;
    tick(acc);
    chk("bp_same_edge_accept", 32'(acc), 32'd1);
    chk("bp_next_data", 32'(rsp_data), 32'h3C);
    req_valid = 1'b0;
    drain();

    // Reset during MAC busy
    drive(FN_MAC, 4'h8, 8'd5, 8'd6, 8'd7);
    req_valid = 1'b1;
    tick(acc);
    req_valid = 1'b0;
    for (int i = 0; i < 3; i++) tick(acc);
    rst_n = 1'b0;
    #1;
    chk("abort_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("abort_req_ready", 32'(req_ready), 32'd1);
    chk("abort_call_cnt", 32'(call_cnt), 32'd0);
    exp_q.delete();
    exp_cnt = '0;
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 15; i++) begin
      if (rsp_valid) seen = 1'b1;
      tick(acc);
    end
    chk("abort_no_stale", 32'(seen), 32'd0);

    // Counter saturation
    force dut.call_cnt = 16'hFFFF;
    #1;
    release dut.call_cnt;
    exp_cnt = 16'hFFFF;
    chk("sat_preload", 32'(call_cnt), 32'hFFFF);
    drive(FN_SEL, 4'hC, 8'h01, 8'h5A, 8'hA5);
    send();
    drain();
    chk("sat_hold", 32'(call_cnt), 32'hFFFF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
